// File: rtl/tipi_pkg.sv
// rtl/tipi_pkg.sv - shared command codes, FSM state type and defaults for the Pi nibble port
package tipi_pkg;

  localparam int SYNC_STAGES_DEF = 2;

  localparam logic [3:0] CMD_RD_TD = 4'h0;
  localparam logic [3:0] CMD_RD_TC = 4'h1;
  localparam logic [3:0] CMD_WR_RD = 4'h2;
  localparam logic [3:0] CMD_WR_RC = 4'h3;

  typedef enum logic [2:0] {
    ST_ABORT = 3'd0,
    ST_CMD   = 3'd1,
    ST_RD_HI = 3'd2,
    ST_RD_LO = 3'd3,
    ST_WR_HI = 3'd4,
    ST_WR_LO = 3'd5,
    ST_DONE  = 3'd6,
    ST_ERR   = 3'd7
  } pi_state_t;

endpackage

// File: rtl/tipi_pi_nibble_port_if.sv
// rtl/tipi_pi_nibble_port_if.sv - Pi pad and TI register signals of the nibble port
interface tipi_pi_nibble_port_if;
  // Pad nibble numbering is MSB-first, so the numeric value of each vector
  // is the value the Pi sees; vectors are declared descending.
  logic       r_clk;
  logic       r_nibrst;
  logic [3:0] r_nib_i;
  logic [3:0] r_nib_o;
  logic       r_nib_oe;
  logic [7:0] td;
  logic [7:0] tc;
  logic [7:0] rd;
  logic [7:0] rc;
  logic       rd_we;
  logic       rc_we;
  logic       frame_err;

  modport master (
    output r_clk, r_nibrst, r_nib_i, td, tc,
    input  r_nib_o, r_nib_oe, rd, rc, rd_we, rc_we, frame_err
  );

  modport slave (
    input  r_clk, r_nibrst, r_nib_i, td, tc,
    output r_nib_o, r_nib_oe, rd, rc, rd_we, rc_we, frame_err
  );
endinterface

// File: rtl/tipi_sync_edge.sv
// rtl/tipi_sync_edge.sv - multi-flop synchroniser with registered rising-edge pulse
module tipi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic level_o,
  output logic rise_o
);

  // One extra flop beyond the synchroniser holds the previous synced level.
  logic [SYNC_STAGES:0] sync_q, sync_d;
  logic                 rise_q, rise_d;

  // Shift the pad value in and flag a low-to-high transition of the synced level.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-1:0], d_i};
    rise_d = sync_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES];
  end

  // Synchroniser chain and pulse register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      rise_q <= rise_d;
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = rise_q;

endmodule

// File: rtl/tipi_pi_nibble_port.sv
// rtl/tipi_pi_nibble_port.sv - Pi-side nibble exchange of the TIPI TD/TC/RD/RC registers
module tipi_pi_nibble_port
  import tipi_pkg::*;
#(
  parameter int         SYNC_STAGES = SYNC_STAGES_DEF,
  parameter logic [7:0] RDRC_RESET  = 8'h00
) (
  input  logic                   clk,
  input  logic                   reset,
  tipi_pi_nibble_port_if.slave   bus
);

  logic rclk_level, strobe;
  logic nibrst_level, nibrst_rise;

  tipi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_rclk_sync (
    .clk     (clk),
    .reset   (reset),
    .d_i     (bus.r_clk),
    .level_o (rclk_level),
    .rise_o  (strobe)
  );

  tipi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_nibrst_sync (
    .clk     (clk),
    .reset   (reset),
    .d_i     (bus.r_nibrst),
    .level_o (nibrst_level),
    .rise_o  (nibrst_rise)
  );

  pi_state_t  state_q, state_d;
  logic [3:0] nib_s_q, nib_s_d;
  logic [7:0] snap_q, snap_d;
  logic       target_rc_q, target_rc_d;
  logic [3:0] hi_q, hi_d;
  logic [7:0] rd_q, rd_d;
  logic [7:0] rc_q, rc_d;
  logic       rd_we_q, rd_we_d;
  logic       rc_we_q, rc_we_d;
  logic       frame_err_q, frame_err_d;
  logic [3:0] nib_o_q, nib_o_d;
  logic       nib_oe_q, nib_oe_d;
  logic       abort;

  // Frame reset wins over everything, including a strobe in the same cycle.
  assign abort = nibrst_level | nibrst_rise;

  // Next-state, datapath and registered pad outputs.
  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    target_rc_d = target_rc_q;
    hi_d        = hi_q;
    rd_d        = rd_q;
    rc_d        = rc_q;
    rd_we_d     = 1'b0;
    rc_we_d     = 1'b0;
    frame_err_d = frame_err_q;

    // Track the Pi nibble while synced r_clk is high; the Pi holds it stable
    // then, so at the strobe this is the value present at edge detection.
    nib_s_d = rclk_level ? bus.r_nib_i : nib_s_q;

    // Pad drive follows the current state, one clk behind each transition.
    nib_oe_d = (state_q == ST_RD_HI) || (state_q == ST_RD_LO);
    nib_o_d  = 4'h0;
    if (state_q == ST_RD_HI) nib_o_d = snap_q[7:4];
    if (state_q == ST_RD_LO) nib_o_d = snap_q[3:0];

    if (state_q == ST_ABORT) frame_err_d = 1'b0;

    if (abort) begin
      state_d = ST_ABORT;
    end else begin
      case (state_q)
        ST_ABORT: state_d = ST_CMD;
        ST_CMD: begin
          if (strobe) begin
            case (nib_s_q)
              CMD_RD_TD: begin snap_d = bus.td; state_d = ST_RD_HI; end
              CMD_RD_TC: begin snap_d = bus.tc; state_d = ST_RD_HI; end
              CMD_WR_RD: begin target_rc_d = 1'b0; state_d = ST_WR_HI; end
              CMD_WR_RC: begin target_rc_d = 1'b1; state_d = ST_WR_HI; end
              default:   begin frame_err_d = 1'b1; state_d = ST_ERR; end
            endcase
          end
        end
        ST_RD_HI: if (strobe) state_d = ST_RD_LO;
        ST_RD_LO: if (strobe) state_d = ST_DONE;
        ST_WR_HI: begin
          if (strobe) begin
            hi_d    = nib_s_q;
            state_d = ST_WR_LO;
          end
        end
        ST_WR_LO: begin
          if (strobe) begin
            if (target_rc_q) begin
              rc_d    = {hi_q, nib_s_q};
              rc_we_d = 1'b1;
            end else begin
              rd_d    = {hi_q, nib_s_q};
              rd_we_d = 1'b1;
            end
            state_d = ST_DONE;
          end
        end
        ST_DONE: state_d = ST_DONE;
        ST_ERR:  state_d = ST_ERR;
        default: state_d = ST_ABORT;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_ABORT;
      nib_s_q     <= 4'h0;
      snap_q      <= 8'h00;
      target_rc_q <= 1'b0;
      hi_q        <= 4'h0;
      rd_q        <= RDRC_RESET;
      rc_q        <= RDRC_RESET;
      rd_we_q     <= 1'b0;
      rc_we_q     <= 1'b0;
      frame_err_q <= 1'b0;
      nib_o_q     <= 4'h0;
      nib_oe_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      nib_s_q     <= nib_s_d;
      snap_q      <= snap_d;
      target_rc_q <= target_rc_d;
      hi_q        <= hi_d;
      rd_q        <= rd_d;
      rc_q        <= rc_d;
      rd_we_q     <= rd_we_d;
      rc_we_q     <= rc_we_d;
      frame_err_q <= frame_err_d;
      nib_o_q     <= nib_o_d;
      nib_oe_q    <= nib_oe_d;
    end
  end

  assign bus.r_nib_o   = nib_o_q;
  assign bus.r_nib_oe  = nib_oe_q;
  assign bus.rd        = rd_q;
  assign bus.rc        = rc_q;
  assign bus.rd_we     = rd_we_q;
  assign bus.rc_we     = rc_we_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_tipi_pi_nibble_port.sv
// tb/tb_tipi_pi_nibble_port.sv - scoreboard bench for the TIPI Pi nibble port
module tb_tipi_pi_nibble_port;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  tipi_pi_nibble_port_if bus ();

  tipi_pi_nibble_port dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pad samples expected at each Pi strobe: {oe, nib}; write results: {is_rc, value}.
  logic [4:0] pad_q[$];
  logic [8:0] wr_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [3:0] nib, input logic eoe, input logic [3:0] enib);
    pad_q.push_back({eoe, enib});
    bus.r_nib_i = nib;
    clks(6);
    bus.r_clk = 1'b1;
    clks(6);
    bus.r_clk = 1'b0;
    clks(2);
  endtask

  task automatic frame_open();
    bus.r_nibrst = 1'b1;
    clks(8);
    bus.r_nibrst = 1'b0;
    clks(8);
  endtask

  task automatic frame_close();
    bus.r_nibrst = 1'b1;
    clks(8);
  endtask

  // Monitor: Pi samples the pads on its r_clk rise; TI side sees rd/rc on we pulses.
  initial begin
    logic       rclk_prev;
    logic       rd_we_prev;
    logic       rc_we_prev;
    logic [4:0] pe;
    logic [8:0] we;
    rclk_prev  = 1'b0;
    rd_we_prev = 1'b0;
    rc_we_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.r_clk === 1'b1 && !rclk_prev) begin
        if (pad_q.size() == 0) begin
          check("pad_unexpected", 32'd1, 32'd0);
        end else begin
          pe = pad_q.pop_front();
          check("pad_oe", 32'(bus.r_nib_oe), 32'(pe[4]));
          if (pe[4]) check("pad_nib", 32'(bus.r_nib_o), 32'(pe[3:0]));
        end
      end
      if (bus.rd_we === 1'b1) begin
        check("rd_we_width", 32'(rd_we_prev), 32'd0);
        if (wr_q.size() == 0) begin
          check("rd_we_unexpected", 32'd1, 32'd0);
        end else begin
          we = wr_q.pop_front();
          check("rd_we_target", 32'(we[8]), 32'd0);
          check("rd_value", 32'(bus.rd), 32'(we[7:0]));
        end
      end
      if (bus.rc_we === 1'b1) begin
        check("rc_we_width", 32'(rc_we_prev), 32'd0);
        if (wr_q.size() == 0) begin
          check("rc_we_unexpected", 32'd1, 32'd0);
        end else begin
          we = wr_q.pop_front();
          check("rc_we_target", 32'(we[8]), 32'd1);
          check("rc_value", 32'(bus.rc), 32'(we[7:0]));
        end
      end
      rclk_prev  = (bus.r_clk === 1'b1);
      rd_we_prev = (bus.rd_we === 1'b1);
      rc_we_prev = (bus.rc_we === 1'b1);
    end
  end

  initial begin
    total        = 0;
    bad          = 0;
    reset        = 1'b0;
    bus.r_clk    = 1'b0;
    bus.r_nibrst = 1'b1;
    bus.r_nib_i  = 4'h0;
    bus.td       = 8'h00;
    bus.tc       = 8'h00;

    // Asynchronous reset takes effect with no clock edge.
    #2 reset = 1'b1;
    #1;
    check("rst_nib_o", 32'(bus.r_nib_o), 32'h0);
    check("rst_oe", 32'(bus.r_nib_oe), 32'h0);
    check("rst_rd", 32'(bus.rd), 32'h00);
    check("rst_rc", 32'(bus.rc), 32'h00);
    check("rst_rd_we", 32'(bus.rd_we), 32'h0);
    check("rst_rc_we", 32'(bus.rc_we), 32'h0);
    check("rst_frame_err", 32'(bus.frame_err), 32'h0);
    #29 reset = 1'b0;
    clks(4);

    // Read TD, plus a fourth strobe after the frame completes.
    bus.td = 8'hA5;
    frame_open();
    strobe(4'h0, 1'b0, 4'h0);
    strobe(4'h0, 1'b1, 4'hA);
    strobe(4'h0, 1'b1, 4'h5);
    strobe(4'h0, 1'b0, 4'h0);
    check("oe_after_read", 32'(bus.r_nib_oe), 32'h0);
    frame_close();

    // Write RC.
    wr_q.push_back({1'b1, 8'hC3});
    frame_open();
    strobe(4'h3, 1'b0, 4'h0);
    strobe(4'hC, 1'b0, 4'h0);
    strobe(4'h3, 1'b0, 4'h0);
    clks(2);
    check("rc_after_write", 32'(bus.rc), 32'hC3);
    check("rd_untouched", 32'(bus.rd), 32'h00);
    frame_close();

    // Snapshot: TC changes after the command is decoded.
    bus.tc = 8'h12;
    frame_open();
    strobe(4'h1, 1'b0, 4'h0);
    bus.tc = 8'hFF;
    strobe(4'h0, 1'b1, 4'h1);
    strobe(4'h0, 1'b1, 4'h2);
    frame_close();

    // Abort mid-write, then a clean write of RD.
    frame_open();
    strobe(4'h2, 1'b0, 4'h0);
    strobe(4'hF, 1'b0, 4'h0);
    frame_close();
    check("rd_after_abort", 32'(bus.rd), 32'h00);
    wr_q.push_back({1'b0, 8'h5A});
    frame_open();
    strobe(4'h2, 1'b0, 4'h0);
    strobe(4'h5, 1'b0, 4'h0);
    strobe(4'hA, 1'b0, 4'h0);
    clks(2);
    check("rd_after_write", 32'(bus.rd), 32'h5A);
    frame_close();

    // Illegal command: sticky error, later strobes ignored, cleared by nibrst.
    frame_open();
    strobe(4'h7, 1'b0, 4'h0);
    check("frame_err_set", 32'(bus.frame_err), 32'h1);
    strobe(4'h0, 1'b0, 4'h0);
    strobe(4'h0, 1'b0, 4'h0);
    check("frame_err_sticky", 32'(bus.frame_err), 32'h1);
    frame_close();
    check("frame_err_cleared", 32'(bus.frame_err), 32'h0);

    // Async reset mid-read, released with the frame already open.
    bus.td = 8'h3C;
    frame_open();
    strobe(4'h0, 1'b0, 4'h0);
    check("oe_mid_read", 32'(bus.r_nib_oe), 32'h1);
    #2 reset = 1'b1;
    #1;
    check("midrst_oe", 32'(bus.r_nib_oe), 32'h0);
    check("midrst_rd", 32'(bus.rd), 32'h00);
    check("midrst_rc", 32'(bus.rc), 32'h00);
    #13 reset = 1'b0;
    clks(8);
    strobe(4'h0, 1'b0, 4'h0);
    strobe(4'h0, 1'b1, 4'h3);
    strobe(4'h0, 1'b1, 4'hC);
    frame_close();

    clks(10);
    check("pad_q_drained", 32'(pad_q.size()), 32'd0);
    check("wr_q_drained", 32'(wr_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
